// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, oversampling constant and baud divider helper
// for the oversampling UART receiver. Defining UART_RX_PARITY_EN adds the
// PARITY state used for 8E1 framing.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;
`endif

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int baud_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV
// clocks. A synchronous clear restarts the count so ticks align to a frame.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; a clear restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with 2-FF input synchroniser,
// majority-vote bit decisions, false-start rejection and framing-error
// reporting. Define UART_RX_PARITY_EN for 8E1 frames with even-parity check;
// otherwise frames are 8N1 and parity_err is tied low.
module uart_rx_os import uart_pkg::*; #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam logic [3:0] TLAST = 4'(OVERSAMPLE - 1);

  logic       sync1, rxs, rxs_prev;
  logic [1:0] sync_fill;
  logic       armed;
  logic       tick, clr;

  rx_state_t  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       s7_q, s7_d, s8_q, s8_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       ferr_q, ferr_d;
  logic       maj, start_edge, decide, boundary;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       perr_q, perr_d;
`endif

  // Synchronise rxd and arm edge detection only once the line has really been
  // seen high, so a line held low across reset release is not a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= rxd;
      rxs       <= sync1;
      rxs_prev  <= rxs;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rxs) begin
        armed <= 1'b1;
      end
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  assign start_edge = armed && rxs_prev && !rxs;
  assign tcnt_inc   = (tcnt_q == TLAST) ? 4'd0 : tcnt_q + 4'd1;
  assign maj        = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
  assign decide     = tick && (tcnt_inc == 4'd9);
  assign boundary   = tick && (tcnt_inc == 4'd0);

  // Next-state and datapath: tcnt holds the index of the latest tick, with the
  // start edge counting as tick 0; samples at 7 and 8, decision at 9.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bitcnt_d   = bitcnt_q;
    idle_cnt_d = idle_cnt_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    clr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    if ((state_q != IDLE) && (state_q != WAIT_IDLE) && tick) begin
      tcnt_d = tcnt_inc;
      if (tcnt_inc == 4'd7) s7_d = rxs;
      if (tcnt_inc == 4'd8) s8_d = rxs;
    end

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = START;
          tcnt_d   = 4'd0;
          bitcnt_d = 4'd0;
          clr      = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_d    = 1'b0;
`endif
        end
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
        end else if (boundary) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shreg_d  = {maj, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          par_d    = par_q ^ maj;
`endif
        end
        if (boundary && (bitcnt_q == 4'd8)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_d = par_q ^ maj;
        end
        if (boundary) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
          if (maj) begin
            data_d  = shreg_q;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
            state_d = IDLE;
          end else begin
            ferr_d     = 1'b1;
            idle_cnt_d = 4'd0;
            state_d    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (tick) begin
          if (!rxs) begin
            idle_cnt_d = 4'd0;
          end else if (idle_cnt_q == 4'd15) begin
            idle_cnt_d = 4'd0;
            state_d    = IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register FSM state, datapath and the one-cycle output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tcnt_q     <= 4'd0;
      bitcnt_q   <= 4'd0;
      idle_cnt_q <= 4'd0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      shreg_q    <= 8'd0;
      data_q     <= 8'd0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      idle_cnt_q <= idle_cnt_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames for uart_rx_os at DIV=4
// (64 clocks per bit); received bytes are compared with the bytes sent.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 250_000;
  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN     = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  localparam int EXP_LAT = 2 + DIV * (16 * 9 + 9) + (PAR_EN ? 16 * DIV : 0);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t_edge      = 0;

  logic [7:0] got_q[$];
  int         done_cyc_q[$];
  logic [7:0] exp_q[$];
  int ferr_cnt       = 0;
  int perr_cnt       = 0;
  int perr_with_done = 0;
  int width_viol     = 0;
  int data_glitch    = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_perr = 1'b0;
  logic [7:0] prev_data = 8'd0;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log pulses, pulse widths and any rx_data change outside rx_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
      prev_ferr = 1'b0;
      prev_perr = 1'b0;
      prev_data = rx_data;
    end else begin
      if (rx_done) begin
        got_q.push_back(rx_data);
        done_cyc_q.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) begin
        perr_cnt++;
        if (rx_done) perr_with_done++;
      end
      if ((rx_done && prev_done) || (frame_err && prev_ferr) || (parity_err && prev_perr))
        width_viol++;
      if ((rx_data !== prev_data) && !rx_done) data_glitch++;
      prev_done = rx_done;
      prev_ferr = frame_err;
      prev_perr = parity_err;
      prev_data = rx_data;
    end
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int pop_got();
    if (got_q.size() == 0) return -1;
    return int'(got_q.pop_front());
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 rxd = v;
    repeat (BIT_CLKS - 1) @(posedge clk);
  endtask

  // One full frame: start, 8 data bits LSB first, optional parity, stop.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_v, input logic par_v);
    @(posedge clk);
    #1 rxd = 1'b0;
    t_edge = cyc;
    repeat (BIT_CLKS - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  task automatic send_byte(input logic [7:0] b);
    apply_stimulus(b, 1'b1, ^b);
  endtask

  initial begin
    logic [7:0] str[4];
    logic [7:0] a5;
    logic [7:0] b;
    int cycs[$];
    int d;
    int ferr_base;

    str[0] = 8'h33; str[1] = 8'h20; str[2] = 8'h34; str[3] = 8'h0D;
    a5 = 8'hA5;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("reset_rx_data", int'(rx_data), 0);
    check_output("reset_rx_done", int'(rx_done), 0);
    check_output("reset_frame_err", int'(frame_err), 0);
    check_output("reset_parity_err", int'(parity_err), 0);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);

    $display("[TB] single byte 0x35");
    send_byte(8'h35);
    idle(2 * BIT_CLKS);
    check_output("count_35", got_q.size(), 1);
    check_range("latency_35", (done_cyc_q.size() > 0) ? done_cyc_q[0] - t_edge : -1,
                EXP_LAT - DIV, EXP_LAT + DIV);
    check_output("data_35", pop_got(), 'h35);
    check_output("hold_35", int'(rx_data), 'h35);
    check_output("ferr_35", ferr_cnt, 0);

    $display("[TB] back-to-back string");
    done_cyc_q.delete();
    for (int i = 0; i < 4; i++) send_byte(str[i]);
    idle(2 * BIT_CLKS);
    check_output("count_str", got_q.size(), 4);
    cycs = done_cyc_q;
    for (int i = 0; i < 3; i++) begin
      d = (cycs.size() > i + 1) ? cycs[i + 1] - cycs[i] : -1;
      check_range("spacing_str", d, DIV * 16 * 10, 1_000_000);
    end
    for (int i = 0; i < 4; i++) check_output("data_str", pop_got(), int'(str[i]));

    $display("[TB] random back-to-back bytes");
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b);
    end
    idle(2 * BIT_CLKS);
    check_output("count_rand", got_q.size(), 6);
    while (exp_q.size() > 0) check_output("data_rand", pop_got(), int'(exp_q.pop_front()));

    $display("[TB] glitch rejection");
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 rxd = 1'b1;
    idle(3 * BIT_CLKS);
    check_output("glitch_no_done", got_q.size(), 0);
    check_output("glitch_no_ferr", ferr_cnt, 0);
    send_byte(8'h41);
    idle(2 * BIT_CLKS);
    check_output("data_41", pop_got(), 'h41);

    $display("[TB] framing error");
    apply_stimulus(8'h55, 1'b0, ^a5[3:0]);
    idle(2 * BIT_CLKS);
    @(posedge clk);
    #1 rxd = 1'b1;
    idle(3 * BIT_CLKS);
    check_output("ferr_count", ferr_cnt, 1);
    check_output("ferr_no_done", got_q.size(), 0);
    check_output("ferr_hold_data", int'(rx_data), 'h41);
    send_byte(8'h31);
    idle(2 * BIT_CLKS);
    check_output("data_31", pop_got(), 'h31);
    check_output("ferr_after_31", ferr_cnt, 1);

    $display("[TB] reset mid-frame");
    ferr_base = ferr_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BIT_CLKS - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(a5[i]);
    @(posedge clk);
    #1 rxd = a5[4];
    idle(32);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_output("rst_rx_data", int'(rx_data), 0);
    check_output("rst_rx_done", int'(rx_done), 0);
    check_output("rst_frame_err", int'(frame_err), 0);
    check_output("rst_parity_err", int'(parity_err), 0);
    idle(8);
    #1 rst_n = 1'b1;
    idle(2 * BIT_CLKS);
    @(posedge clk);
    #1 rxd = 1'b1;
    idle(3 * BIT_CLKS);
    check_output("rst_low_no_done", got_q.size(), 0);
    check_output("rst_low_no_ferr", ferr_cnt, ferr_base);
    send_byte(8'h5A);
    idle(2 * BIT_CLKS);
    check_output("data_5a", pop_got(), 'h5A);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity check");
    apply_stimulus(8'h07, 1'b1, 1'b1);
    idle(2 * BIT_CLKS);
    check_output("par_ok_data", pop_got(), 'h07);
    check_output("par_ok_perr", perr_cnt, 0);
    apply_stimulus(8'h07, 1'b1, 1'b0);
    idle(2 * BIT_CLKS);
    check_output("par_bad_data", pop_got(), 'h07);
    check_output("par_bad_perr", perr_cnt, 1);
    check_output("par_bad_with_done", perr_with_done, 1);
    check_output("par_bad_rx_data", int'(rx_data), 'h07);
`else
    check_output("no_parity_err", perr_cnt, 0);
`endif

    check_output("pulse_width", width_viol, 0);
    check_output("data_stable", data_glitch, 0);
    check_output("no_extra_done", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
